shifter_seq: RTL
================

Name: shifter_seq

Overview:
- Parametrised, multi-cycle shift unit. Next generation of the single-cycle shifter, for wider datapaths and for targets that cannot afford a full barrel shifter.
- Shifts at most STEP bit positions per clock.
- Adds right-arithmetic shifts and a valid/ready handshake on both sides.
- Sits in the execute stage beside the ALU. The controller stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 8.
- STEP, 4, maximum shift positions applied per cycle; power of two, 1..WIDTH/2.
- SHW, $clog2(WIDTH), width of shift amounts; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- a  in  WIDTH  variable shift source; only a[SHW-1:0] is used.
- b  in  WIDTH  operand to shift.
- control  in  3  [2]: amount source; [1:0]: operation.
- lui  in  1  load-upper-immediate: shift b left by WIDTH/2.
- constant_shift  in  SHW  immediate shift amount.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  shifted value.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high, port name reset.
- Reset values: state=IDLE, out_valid=0, result=0, internal remaining count=0, busy=0. in_ready=1 (it is decoded from IDLE).
- Reset mid-operation: aborts immediately. No out_valid is produced for the aborted request.
- Amount select (latched at accept):
  - lui=1 -> WIDTH/2, with op forced to left-logical; lui overrides control.
  - else control[2]=0 -> a[SHW-1:0].
  - else control[2]=1 -> constant_shift.
- Op select, control[1:0]:
  - 00: right logical, zero fill.
  - 01: right arithmetic, fill with b[WIDTH-1] captured at accept.
  - 10: left logical.
  - 11: see Optional Feature.
- Accept: in_valid && in_ready at a rising edge. At that edge, latch b into the working register, plus the op and the amount.
- FSM: IDLE -> SHIFT (amount != 0) or IDLE -> DONE (amount == 0).
- SHIFT, each cycle:
  - Apply k = min(remaining, STEP) positions; remaining -= k.
  - When remaining reaches 0 at this edge -> DONE.
- DONE:
  - out_valid=1 and result = working register; both held stable until out_ready.
  - out_valid && out_ready -> IDLE.
  - No same-cycle re-accept: in_ready=0 in DONE.
- Latency: out_valid rises 1 + ceil(amount/STEP) cycles after the accept edge. Amount 0 takes 1 cycle; WIDTH=32, STEP=4, amount 31 takes 9.
- in_ready=1 only in IDLE. in_valid in other states is ignored; inputs need only be valid in the accept cycle.
- Width rules: amounts are 0..WIDTH-1. Bits shifted out are discarded. The sign bit is replicated for arithmetic right shifts; an all-ones operand stays all-ones.
- result outside DONE keeps its last value. It is not required to be meaningful.

Optional Feature:
- Macro: SHIFTER_ROTATE_EN.
- Defined: control[1:0]=11 is rotate right. Bits leaving the LSB re-enter at the MSB, STEP per cycle, same latency rule.
- Not defined: control[1:0]=11 decodes as left logical (legacy encoding); no rotate logic is synthesised.

Test Plan (WIDTH=32, STEP=4):
- SLL, control=3'b010, a=31, b=32'h0000_0001 -> result 32'h8000_0000; out_valid exactly 9 cycles after accept.
- SRA, control=3'b101, constant_shift=4, b=32'h8000_0000 -> 32'hF800_0000 at latency 2. Repeat with control=3'b100 -> 32'h0800_0000.
- lui=1, control=3'b000, b=32'h0000_1234 -> 32'h1234_0000 at latency 5. Amount 0 with b=32'hDEAD_BEEF -> 32'hDEAD_BEEF at latency 1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> result and out_valid stable, in_ready=0. A new in_valid during that time is not accepted. Back-to-back requests complete in order.
- Reset asserted 2 cycles into a 31-position shift, asynchronously between edges -> out_valid=0, busy=0, in_ready=1 immediately. The next request completes normally.
- control=3'b011, a=4, b=32'h0000_00F1:
  - With SHIFTER_ROTATE_EN: 32'h1000_000F.
  - Without SHIFTER_ROTATE_EN: 32'h0000_0F10.

Source files
------------

// File: rtl/shifter_seq.sv
// ============================================================================
//  Module      : shifter_seq
//  Description : Multi-cycle shift unit with valid/ready handshakes. Applies
//                at most STEP bit positions per clock. Supports right
//                logical, right arithmetic and left logical shifts, and a
//                load-upper-immediate mode (shift left by WIDTH/2).
//                Optional macro SHIFTER_ROTATE_EN: control[1:0]=11 becomes
//                rotate right; otherwise 11 decodes as left logical.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shifter_seq #(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       control,
  input  logic             lui,
  input  logic [SHW-1:0]   constant_shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] OP_SRL = 2'd0;
  localparam logic [1:0] OP_SRA = 2'd1;
  localparam logic [1:0] OP_SLL = 2'd2;
  localparam logic [1:0] OP_ROR = 2'd3;

  localparam logic [SHW-1:0] C_STEP_AMT = SHW'(STEP);
  localparam logic [SHW-1:0] C_LUI_AMT  = SHW'(WIDTH / 2);
  localparam logic [SHW:0]   C_WIDTH    = (SHW + 1)'(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [SHW-1:0]   w_acc_amt;
  logic [1:0]       w_acc_op;
  logic [SHW-1:0]   w_k;
  logic [SHW-1:0]   w_rem_next;
  logic [WIDTH-1:0] w_shifted;
  logic             w_unused_a;

  // Only the low SHW bits of a carry a shift amount.
  assign w_unused_a = ^a[WIDTH-1:SHW];

  // Decode amount and operation of the request presented this cycle.
  always_comb begin
    w_acc_amt = control[2] ? constant_shift : a[SHW-1:0];
    w_acc_op  = control[1:0];
`ifndef SHIFTER_ROTATE_EN
    // Legacy encoding: 11 behaves as a left logical shift.
    if (control[1:0] == OP_ROR) begin
      w_acc_op = OP_SLL;
    end
`endif
    if (lui) begin
      w_acc_amt = C_LUI_AMT;
      w_acc_op  = OP_SLL;
    end
  end

  // One shift step: k = min(remaining, STEP) positions.
  always_comb begin
    w_k        = (rem_q < C_STEP_AMT) ? rem_q : C_STEP_AMT;
    w_rem_next = rem_q - w_k;
    case (op_q)
      OP_SRL:  w_shifted = work_q >> w_k;
      // The working MSB still holds the sign captured at accept.
      OP_SRA:  w_shifted = WIDTH'($signed(work_q) >>> w_k);
`ifdef SHIFTER_ROTATE_EN
      OP_ROR:  w_shifted = (work_q >> w_k) | (work_q << (C_WIDTH - {1'b0, w_k}));
`endif
      default: w_shifted = work_q << w_k;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = (w_acc_amt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_rem_next == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs, decoded from the current state.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
  end

  // Datapath next values: latch at accept, shift in SHIFT, freeze result on DONE entry.
  always_comb begin
    work_d   = work_q;
    rem_d    = rem_q;
    op_d     = op_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d = b;
          rem_d  = w_acc_amt;
          op_d   = w_acc_op;
          if (w_acc_amt == '0) begin
            result_d = b;
          end
        end
      end
      S_SHIFT: begin
        work_d = w_shifted;
        rem_d  = w_rem_next;
        if (w_rem_next == '0) begin
          result_d = w_shifted;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work_q   <= '0;
      rem_q    <= '0;
      op_q     <= OP_SRL;
      result_q <= '0;
    end else begin
      work_q   <= work_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

`default_nettype wire
